wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the conflict counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst as elsewhere in the codebase.
REQ-003 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 The block SHALL have ports a_valid (input, 1), a_ready (output, 1), a_reg (input, 5), a_data (input, 32), a_ovf (input, 1): ALU write-back request; a_ovf = overflow trap on this result.
REQ-006 The block SHALL have ports m_valid (input, 1), m_ready (output, 1), m_reg (input, 5), m_data (input, 32): load/memory write-back request.
REQ-007 The block SHALL have port stall, input, 1: blocks new acceptances.
REQ-008 The block SHALL have ports regwrite (output, 1), wrreg (output, 5), wrdata (output, 32): the register-file write port.
REQ-009 The block SHALL have port ovf_err, output, 1: one-cycle pulse for a suppressed overflow write.
REQ-010 The block SHALL have port conflict_cnt, output, CNT_W: saturating count of contention cycles.

Function
REQ-011 A transfer SHALL occur on a rising edge where x_valid and x_ready are both 1.
REQ-012 a_ready and m_ready SHALL be combinational, mutually exclusive, and 0 whenever stall=1 or rst=1.
REQ-013 With exactly one valid requester and stall=0, that requester's ready SHALL be 1.
REQ-014 With both requesters valid and stall=0, the grant SHALL follow the arbitration policy (REQ-025/026).
REQ-015 last_grant SHALL be a 1-bit state (A or M), updated to the accepted requester on every transfer, and held otherwise.
REQ-016 Write-back latency SHALL be exactly 1 cycle: regwrite, wrreg and wrdata are registered and reflect the transfer accepted on the previous edge.
REQ-017 An accepted request with reg=0 SHALL produce regwrite=0, with wrreg/wrdata still updated.
REQ-018 An accepted A request with a_ovf=1 SHALL produce regwrite=0 and ovf_err=1 for exactly one cycle.
REQ-019 In any cycle following an edge with no transfer, regwrite=0 and ovf_err=0, and wrreg/wrdata SHALL hold their previous values.
REQ-020 conflict_cnt SHALL increment by 1 on each edge where a_valid=1, m_valid=1 and stall=0, saturating at 2^CNT_W-1 without wrap.
REQ-021 An unaccepted request SHALL be held by its source; the arbiter SHALL NOT drop or duplicate any accepted request.

Reset
REQ-022 When rst=1 at an edge, regwrite, ovf_err, wrreg, wrdata and conflict_cnt SHALL be set to 0, and last_grant SHALL be set to M.
REQ-023 A request valid during a reset cycle SHALL NOT be accepted (ready=0 per REQ-012) and SHALL be accepted normally after rst falls.
REQ-024 A transfer accepted on the edge before rst rises SHALL have its write output overwritten to regwrite=0 by the reset edge.

Configuration
REQ-025 With macro WB_RR_EN defined, contention SHALL be round-robin: grant the requester opposite last_grant, so A wins the first conflict after reset.
REQ-026 Without WB_RR_EN, contention SHALL be fixed-priority with M always winning; last_grant is still maintained but unused for arbitration.

Verification
REQ-027 The bench SHALL apply reset, then a_valid=1, a_reg=5, a_data=0x1234 for one cycle -> a_ready=1, and the next cycle shows regwrite=1, wrreg=5, wrdata=0x00001234.
REQ-028 The bench SHALL hold both valid for 4 cycles with WB_RR_EN (a_reg=1, m_reg=2) -> grants A,M,A,M, wrreg sequence 1,2,1,2, conflict_cnt=4.
REQ-029 The bench SHALL repeat REQ-028 without WB_RR_EN -> M is granted every cycle, a_ready stays 0, and conflict_cnt=4.
REQ-030 The bench SHALL send A with a_ovf=1, a_reg=7 -> next cycle regwrite=0 and ovf_err=1 for one cycle; then send m_reg=0 -> regwrite=0 and ovf_err=0.
REQ-031 The bench SHALL hold stall=1 for 3 cycles with m_valid=1 -> m_ready=0 and regwrite=0 throughout, conflict_cnt unchanged; on stall release, a single write occurs one cycle later.
REQ-032 The bench SHALL set CNT_W=2 and hold contention for 5 cycles -> conflict_cnt=3; and assert rst mid-burst -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source register write-back arbiter (ALU vs load) with conflict counter; define WB_RR_EN for round-robin contention, otherwise M has fixed priority
module wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_reg,
    input  logic [31:0]      a_data,
    input  logic             a_ovf,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [4:0]       m_reg,
    input  logic [31:0]      m_data,
    input  logic             stall,
    output logic             regwrite,
    output logic [4:0]       wrreg,
    output logic [31:0]      wrdata,
    output logic             ovf_err,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic {GR_M, GR_A} grant_t;
    grant_t last_grant;
    logic   open;
    logic   both;
    logic   a_wins;
    logic   a_xfer;
    logic   m_xfer;
    // grant decision: ready only when not stalled or in reset, A wins contention by policy
    always_comb begin
        open    = !rst && !stall;
        both    = a_valid && m_valid;
`ifdef WB_RR_EN
        a_wins  = last_grant == GR_M;
`else
        a_wins  = 1'b0;
`endif
        a_ready = open && a_valid && (!m_valid || a_wins);
        m_ready = open && m_valid && (!a_valid || !a_wins);
        a_xfer  = a_valid && a_ready;
        m_xfer  = m_valid && m_ready;
    end
    // registered write port, overflow pulse, grant history and saturating contention count
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite     <= 1'b0;
            ovf_err      <= 1'b0;
            wrreg        <= '0;
            wrdata       <= '0;
            conflict_cnt <= '0;
            last_grant   <= GR_M;
        end else begin
            regwrite <= 1'b0;
            ovf_err  <= 1'b0;
            if (a_xfer) begin
                wrreg      <= a_reg;
                wrdata     <= a_data;
                regwrite   <= a_reg != 5'd0 && !a_ovf;
                ovf_err    <= a_ovf;
                last_grant <= GR_A;
            end else if (m_xfer) begin
                wrreg      <= m_reg;
                wrdata     <= m_data;
                regwrite   <= m_reg != 5'd0;
                last_grant <= GR_M;
            end
            if (both && !stall && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (expectations follow WB_RR_EN)
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, a_ovf = 1'b0, m_valid = 1'b0, stall = 1'b0;
    logic [4:0]  a_reg = '0, m_reg = '0;
    logic [31:0] a_data = '0, m_data = '0;
    logic        a_ready, m_ready, regwrite, ovf_err;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic [15:0] conflict_cnt;
    logic        s_a_ready, s_m_ready, s_regwrite, s_ovf_err;
    logic [4:0]  s_wrreg;
    logic [31:0] s_wrdata;
    logic [1:0]  s_cnt;
    int          checks = 0;
    int          failures = 0;
    bit          rr;
    logic [15:0] cnt_hold;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data), .a_ovf(a_ovf),
        .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
        .stall(stall), .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
        .ovf_err(ovf_err), .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(s_a_ready), .a_reg(a_reg), .a_data(a_data), .a_ovf(a_ovf),
        .m_valid(m_valid), .m_ready(s_m_ready), .m_reg(m_reg), .m_data(m_data),
        .stall(stall), .regwrite(s_regwrite), .wrreg(s_wrreg), .wrdata(s_wrdata),
        .ovf_err(s_ovf_err), .conflict_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef WB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        check("rst_regwrite", regwrite, 0);
        check("rst_wrreg", wrreg, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_cnt", conflict_cnt, 0);

        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
        #1;
        check("rst_blocks_ready", a_ready, 0);
        tick();
        check("rst_no_accept", regwrite, 0);
        rst = 1'b0;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_m_ready", m_ready, 0);
        tick();
        a_valid = 1'b0;
        check("single_regwrite", regwrite, 1);
        check("single_wrreg", wrreg, 5);
        check("single_wrdata", wrdata, 32'h0000_1234);
        tick();
        check("idle_regwrite", regwrite, 0);
        check("idle_wrreg_hold", wrreg, 5);
        check("idle_wrdata_hold", wrdata, 32'h0000_1234);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hAAAA_0001;
        m_valid = 1'b1; m_reg = 5'd2; m_data = 32'hBBBB_0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("cont_a_ready%0d", i), a_ready, (rr && i % 2 == 0) ? 1 : 0);
            check($sformatf("cont_m_ready%0d", i), m_ready, (rr && i % 2 == 0) ? 0 : 1);
            tick();
            check($sformatf("cont_wrreg%0d", i), wrreg, (rr && i % 2 == 0) ? 1 : 2);
            check($sformatf("cont_wrdata%0d", i), wrdata,
                  (rr && i % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
            check($sformatf("cont_regwrite%0d", i), regwrite, 1);
            check($sformatf("cont_cnt%0d", i), conflict_cnt, i + 1);
            check($sformatf("cont_small_cnt%0d", i), s_cnt, (i + 1 > 3) ? 3 : i + 1);
        end

        rst = 1'b1;
        #1;
        check("rst_mid_a_ready", a_ready, 0);
        check("rst_mid_m_ready", m_ready, 0);
        tick();
        rst = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
        check("rst_mid_regwrite", regwrite, 0);
        check("rst_mid_wrreg", wrreg, 0);
        check("rst_mid_wrdata", wrdata, 0);
        check("rst_mid_ovf", ovf_err, 0);
        check("rst_mid_cnt", conflict_cnt, 0);
        check("rst_mid_small_cnt", s_cnt, 0);

        a_valid = 1'b1; a_reg = 5'd7; a_ovf = 1'b1; a_data = 32'hDEAD_BEEF;
        tick();
        a_valid = 1'b0; a_ovf = 1'b0;
        check("ovf_regwrite", regwrite, 0);
        check("ovf_err", ovf_err, 1);
        check("ovf_wrreg", wrreg, 7);
        tick();
        check("ovf_pulse_end", ovf_err, 0);
        m_valid = 1'b1; m_reg = 5'd0; m_data = 32'h55;
        tick();
        m_valid = 1'b0;
        check("r0_regwrite", regwrite, 0);
        check("r0_ovf", ovf_err, 0);
        check("r0_wrreg", wrreg, 0);
        check("r0_wrdata", wrdata, 32'h55);

        cnt_hold = conflict_cnt;
        stall = 1'b1; m_valid = 1'b1; m_reg = 5'd3; m_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_m_ready%0d", i), m_ready, 0);
            tick();
            check($sformatf("stall_regwrite%0d", i), regwrite, 0);
            check($sformatf("stall_cnt%0d", i), conflict_cnt, cnt_hold);
        end
        stall = 1'b0;
        #1;
        check("unstall_m_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        check("unstall_regwrite", regwrite, 1);
        check("unstall_wrreg", wrreg, 3);
        check("unstall_wrdata", wrdata, 32'h77);
        tick();
        check("unstall_single", regwrite, 0);

        stall = 1'b1; a_valid = 1'b1; m_valid = 1'b1;
        tick();
        check("stall_both_cnt", conflict_cnt, cnt_hold);
        check("stall_both_regwrite", regwrite, 0);
        stall = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
